// File: rtl/uc_irq.sv
// uc_irq: microcontroller control unit with instruction decode, FSM and 4-line edge-triggered interrupt controller
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   opcode[15:0]         - current instruction, op = opcode[15:12]
//   z, carry             - registered ALU flags
//   irq[3:0]             - interrupt request levels, irq[0] highest priority
//   s_inc..s_ent, port, op_alu - datapath strobes and selects
//   hold                 - freezes the PC
//   int_sel, int_addr    - vector jump select and target address
//   ret_cur              - push current PC instead of PC+1
//   ie, in_svc           - global interrupt enable, handler active
module uc_irq #(
    parameter logic [9:0] VEC_BASE = 10'h3F0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] opcode,
    input  logic        z,
    input  logic        carry,
    input  logic [3:0]  irq,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic        push,
    output logic        pop,
    output logic        s_ent,
    output logic [1:0]  port,
    output logic [2:0]  op_alu,
    output logic        hold,
    output logic        int_sel,
    output logic [9:0]  int_addr,
    output logic        ret_cur,
    output logic        ie,
    output logic        in_svc
);
    typedef enum logic [1:0] {RUN, INT_ENTRY, HALT, WAKE} state_t;
    state_t state, nxt;
    logic [3:0] op, mask, pending, irq_q, pm, ack;
    logic [1:0] vec, vec_q;
    logic [9:0] vaddr;
    logic take, branch, do_ei, do_di, do_reti;
    logic unused_ok;
    assign unused_ok = ^{opcode[5:0], carry};
    assign op = opcode[15:12];
    assign pm = pending & mask;
    assign take = ie & ~in_svc & (|pm);
    assign vec = pm[0] ? 2'd0 : pm[1] ? 2'd1 : pm[2] ? 2'd2 : 2'd3;
    assign vaddr = VEC_BASE + {6'd0, vec, 2'b00};
    // flow-control opcodes J..RET finish before an interrupt can be taken
    assign branch = (op >= 4'hA) && (op <= 4'hE);
    // vector is latched at the take cycle so a late higher-priority edge cannot change which bit is acked
    assign ack = (state == INT_ENTRY) ? (4'b0001 << vec_q) : 4'b0000;
    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3 = 1'b0;
        wez = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        s_ent = 1'b0;
        port = 2'b00;
        op_alu = 3'b000;
        hold = 1'b0;
        int_sel = 1'b0;
        int_addr = 10'd0;
        ret_cur = 1'b0;
        nxt = state;
        do_ei = 1'b0;
        do_di = 1'b0;
        do_reti = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (take && !branch) begin
                        s_inc = 1'b0;
                        push = 1'b1;
                        int_sel = 1'b1;
                        int_addr = vaddr;
                        ret_cur = 1'b1;
                        nxt = INT_ENTRY;
                    end else if (!op[3]) begin
                        op_alu = op[2:0];
                        we3 = 1'b1;
                        wez = 1'b1;
                    end else begin
                        case (op[2:0])
                            3'b000: begin s_inm = 1'b1; we3 = 1'b1; end
                            3'b001: begin s_inm = 1'b1; s_ent = 1'b1; port = opcode[11:10]; we3 = 1'b1; end
                            3'b010: s_inc = 1'b0;
                            3'b011: s_inc = ~z;
                            3'b100: s_inc = z;
                            3'b101: begin push = 1'b1; s_inc = 1'b0; end
                            3'b110: begin pop = 1'b1; do_reti = opcode[11]; end
                            default: begin
                                do_ei = opcode[11:10] == 2'b01;
                                do_di = opcode[11:10] == 2'b10;
                                nxt = (opcode[11:10] == 2'b11) ? HALT : RUN;
                            end
                        endcase
                    end
                end
                INT_ENTRY: begin
                    s_inc = 1'b0;
                    hold = 1'b1;
                    nxt = RUN;
                end
                HALT: begin
                    s_inc = 1'b0;
                    if (take) begin
                        push = 1'b1;
                        int_sel = 1'b1;
                        int_addr = vaddr;
                        nxt = INT_ENTRY;
                    end else begin
                        hold = 1'b1;
                        nxt = (!ie && (|pm)) ? WAKE : HALT;
                    end
                end
                default: nxt = RUN;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            ie <= 1'b0;
            in_svc <= 1'b0;
            mask <= 4'd0;
            pending <= 4'd0;
            irq_q <= 4'd0;
            vec_q <= 2'd0;
        end else begin
            state <= nxt;
            irq_q <= irq;
            // a new edge on the bit being acknowledged survives the ack
            pending <= (pending & ~ack) | (irq & ~irq_q);
            if (int_sel) vec_q <= vec;
            if (state == INT_ENTRY) begin
                in_svc <= 1'b1;
                ie <= 1'b0;
            end
            if (do_ei) begin
                mask <= opcode[9:6];
                ie <= 1'b1;
            end
            if (do_di) ie <= 1'b0;
            if (do_reti) begin
                in_svc <= 1'b0;
                ie <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uc_irq.sv
// tb_uc_irq: directed self-checking bench for uc_irq
module tb_uc_irq;
    logic clk = 1'b0;
    logic reset;
    logic [15:0] opcode;
    logic z, carry;
    logic [3:0] irq;
    logic s_inc, s_inm, we3, wez, push, pop, s_ent, hold, int_sel, ret_cur, ie, in_svc;
    logic [1:0] port;
    logic [2:0] op_alu;
    logic [9:0] int_addr;
    logic [9:0] strb;
    int vectors = 0;
    int miscompares = 0;
    uc_irq #(.VEC_BASE(10'h3F0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .carry(carry), .irq(irq),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .push(push), .pop(pop),
        .s_ent(s_ent), .port(port), .op_alu(op_alu), .hold(hold), .int_sel(int_sel),
        .int_addr(int_addr), .ret_cur(ret_cur), .ie(ie), .in_svc(in_svc)
    );
    always #5 clk = ~clk;
    assign strb = {s_inc, s_inm, we3, wez, push, pop, s_ent, hold, int_sel, ret_cur};
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic set(input logic [15:0] o, input logic zz, input logic [3:0] ir);
        opcode = o;
        z = zz;
        irq = ir;
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        reset = 1'b1;
        carry = 1'b0;
        set(16'hA000, 1'b0, 4'b0000);
        tick;
        chk("rst_strb", 16'(strb), 16'b1000000000);
        chk("rst_addr", 16'(int_addr), 16'h0);
        chk("rst_flags", {14'd0, ie, in_svc}, 16'h0);
        reset = 1'b0;
        set(16'h3000, 1'b0, 4'b0000);
        chk("alu_strb", 16'(strb), 16'b1011000000);
        chk("alu_op", 16'(op_alu), 16'h3);
        set(16'hB000, 1'b1, 4'b0000);
        chk("jz_taken", 16'(strb), 16'b0000000000);
        set(16'hB000, 1'b0, 4'b0000);
        chk("jz_not", 16'(strb), 16'b1000000000);
        set(16'h8000, 1'b0, 4'b0000);
        chk("loadi", {3'd0, op_alu, strb}, {3'd0, 3'd0, 10'b1110000000});
        set(16'h9800, 1'b0, 4'b0000);
        chk("in_strb", 16'(strb), 16'b1110001000);
        chk("in_port", 16'(port), 16'h2);
        set(16'hD000, 1'b0, 4'b0000);
        chk("call", 16'(strb), 16'b0000100000);
        set(16'hC000, 1'b1, 4'b0000);
        chk("jnz_z1", 16'(strb), 16'b1000000000);
        set(16'hF7C0, 1'b0, 4'b0000);
        tick;
        chk("ei_flags", {14'd0, ie, in_svc}, 16'b10);
        set(16'h0000, 1'b0, 4'b0110);
        chk("pre_edge_alu", 16'(strb), 16'b1011000000);
        tick;
        chk("pend_0110", 16'(dut.pending), 16'h6);
        chk("take1_strb", 16'(strb), 16'b0000100011);
        chk("take1_addr", 16'(int_addr), 16'h3F4);
        tick;
        chk("entry1", 16'(strb), 16'b0000000100);
        tick;
        chk("pend_0100", 16'(dut.pending), 16'h4);
        chk("svc1_flags", {14'd0, ie, in_svc}, 16'b01);
        chk("handler_alu", 16'(strb), 16'b1011000000);
        set(16'hE800, 1'b0, 4'b0110);
        chk("reti_strb", 16'(strb), 16'b1000010000);
        tick;
        chk("reti_flags", {14'd0, ie, in_svc}, 16'b10);
        set(16'h0000, 1'b0, 4'b0110);
        chk("take2_strb", 16'(strb), 16'b0000100011);
        chk("take2_addr", 16'(int_addr), 16'h3F8);
        tick;
        tick;
        chk("pend_0000", 16'(dut.pending), 16'h0);
        chk("svc2_flags", {14'd0, ie, in_svc}, 16'b01);
        set(16'hE800, 1'b0, 4'b0110);
        tick;
        set(16'hF800, 1'b0, 4'b0110);
        tick;
        chk("di_flags", {14'd0, ie, in_svc}, 16'b00);
        set(16'hFC00, 1'b0, 4'b0110);
        chk("halt_instr", 16'(strb), 16'b1000000000);
        tick;
        set(16'h0000, 1'b0, 4'b1000);
        chk("halt_idle", 16'(strb), 16'b0000000100);
        tick;
        chk("halt_pend3", 16'(dut.pending), 16'h8);
        chk("halt_hold", 16'(strb), 16'b0000000100);
        tick;
        chk("wake", 16'(strb), 16'b1000000000);
        tick;
        chk("after_wake", 16'(strb), 16'b1011000000);
        chk("wake_pend3", 16'(dut.pending), 16'h8);
        set(16'hF400, 1'b0, 4'b1000);
        tick;
        set(16'h0000, 1'b0, 4'b1010);
        chk("masked_alu0", 16'(strb), 16'b1011000000);
        tick;
        chk("masked_pend", 16'(dut.pending), 16'hA);
        chk("masked_alu1", 16'(strb), 16'b1011000000);
        set(16'hF480, 1'b0, 4'b1010);
        chk("ei0010", 16'(strb), 16'b1000000000);
        tick;
        set(16'hA000, 1'b0, 4'b1010);
        chk("branch_defer", 16'(strb), 16'b0000000000);
        set(16'h0000, 1'b0, 4'b1010);
        chk("unmask_take", 16'(strb), 16'b0000100011);
        chk("unmask_addr", 16'(int_addr), 16'h3F4);
        tick;
        reset = 1'b1;
        set(16'h0000, 1'b0, 4'b0000);
        chk("rst_entry_strb", 16'(strb), 16'b1000000000);
        chk("rst_entry_addr", 16'(int_addr), 16'h0);
        tick;
        reset = 1'b0;
        set(16'h0000, 1'b0, 4'b0000);
        chk("post_rst_flags", {14'd0, ie, in_svc}, 16'b00);
        chk("post_rst_pend", 16'(dut.pending), 16'h0);
        chk("post_rst_alu", 16'(strb), 16'b1011000000);
        set(16'hF7C0, 1'b0, 4'b0000);
        tick;
        set(16'hFC00, 1'b0, 4'b0000);
        tick;
        set(16'h0000, 1'b0, 4'b0001);
        tick;
        chk("halt_take", {13'd0, push, int_sel, ret_cur}, 16'b110);
        chk("halt_take_addr", 16'(int_addr), 16'h3F0);
        tick;
        chk("halt_entry", 16'(strb), 16'b0000000100);
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
